// File: rtl/filter_pkg.sv
// Shared definitions for the 3x3 window filter: filter mode codes and controller states.
package filter_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_MIN  = 2'd1;
    localparam logic [1:0] MODE_MAX  = 2'd2;
    localparam logic [1:0] MODE_MED  = 2'd3;

    localparam int WIN_N = 9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/median9.sv
// Exact median of nine unsigned samples: each sample gets a unique rank and rank 4 is selected.
module median9
    import filter_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] pix [WIN_N],
    output logic [PIX_W-1:0] med
);

    logic [WIN_N-1:0] hit;

    // Ties are broken by index so the nine ranks always form a permutation of 0..8.
    for (genvar gi = 0; gi < WIN_N; gi++) begin : g_rank
        logic [3:0] rank;

        always_comb begin
            rank = 4'd0;
            for (int j = 0; j < WIN_N; j++) begin
                if (j < gi) begin
                    if (pix[j] <= pix[gi]) rank = rank + 4'd1;
                end else if (j > gi) begin
                    if (pix[j] < pix[gi]) rank = rank + 4'd1;
                end
            end
        end

        assign hit[gi] = (rank == 4'd4);
    end

    always_comb begin
        med = '0;
        for (int i = 0; i < WIN_N; i++) begin
            if (hit[i]) med = pix[i];
        end
    end

endmodule

// File: rtl/window_filter_engine.sv
// Streams a padded image once, slides a 3x3 window through two line buffers and writes
// one filtered pixel (center/min/max/median) for every interior window position.
module window_filter_engine
    import filter_pkg::*;
#(
    parameter int  IMG_W = 256,
    parameter int  IMG_H = 256,
    parameter int  PIX_W = 8,
    localparam int PW    = IMG_W + 2,
    localparam int PH    = IMG_H + 2,
    localparam int RA_W  = $clog2(PW * PH),
    localparam int WA_W  = $clog2(IMG_W * IMG_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic             rd_en,
    output logic [RA_W-1:0]  rd_addr,
    input  logic [PIX_W-1:0] rd_data,
    output logic             wr_en,
    output logic [WA_W-1:0]  wr_addr,
    output logic [PIX_W-1:0] wr_data,
    output logic             busy,
    output logic             done
);

    localparam int NPIX = PW * PH;
    localparam int CW   = $clog2(PW);
    localparam int RW   = $clog2(PH);

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             drain_q, drain_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start;

    logic             rd_en_q, rd_en_d;
    logic [RA_W-1:0]  rd_addr_q, rd_addr_d;
    logic [CW-1:0]    rd_col_q, rd_col_d;
    logic [RW-1:0]    rd_row_q, rd_row_d;

    logic             vld_q, vld_d;
    logic [CW-1:0]    d_col_q, d_col_d;
    logic [RW-1:0]    d_row_q, d_row_d;

    logic [PIX_W-1:0] lb0_mem [PW];
    logic [PIX_W-1:0] lb1_mem [PW];
    logic [PIX_W-1:0] lb0_rd_q, lb1_rd_q;

    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_d [3][3];
    logic [PIX_W-1:0] win_flat [WIN_N];
    logic [PIX_W-1:0] min_v, max_v, med_v;

    logic             wr_en_q, wr_en_d;
    logic [WA_W-1:0]  wr_addr_q, wr_addr_d;
    logic [WA_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [PIX_W-1:0] wr_data_q, wr_data_d;

    assign start = (state_q == S_IDLE) && en;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        drain_d   = drain_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        rd_col_d  = rd_col_q;
        rd_row_d  = rd_row_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d   = S_RUN;
                    mode_d    = mode;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    rd_col_d  = '0;
                    rd_row_d  = '0;
                end
            end
            S_RUN: begin
                if (rd_addr_q == RA_W'(NPIX - 1)) begin
                    state_d = S_DRAIN;
                    rd_en_d = 1'b0;
                    drain_d = 1'b0;
                end else begin
                    rd_addr_d = rd_addr_q + RA_W'(1);
                    if (rd_col_q == CW'(PW - 1)) begin
                        rd_col_d = '0;
                        rd_row_d = rd_row_q + RW'(1);
                    end else begin
                        rd_col_d = rd_col_q + CW'(1);
                    end
                end
            end
            // Two cycles cover the read latency plus the output register.
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Position tags follow the read strobe so they line up with rd_data.
    always_comb begin
        vld_d   = rd_en_q;
        d_col_d = rd_en_q ? rd_col_q : d_col_q;
        d_row_d = rd_en_q ? rd_row_q : d_row_q;
        win_d   = win_q;
        if (vld_q) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd_q;
            win_d[1][2] = lb0_rd_q;
            win_d[2][2] = rd_data;
        end
    end

    for (genvar gi = 0; gi < WIN_N; gi++) begin : g_flat
        assign win_flat[gi] = win_d[gi / 3][gi % 3];
    end

    always_comb begin
        min_v = win_flat[0];
        max_v = win_flat[0];
        for (int i = 1; i < WIN_N; i++) begin
            if (win_flat[i] < min_v) min_v = win_flat[i];
            if (win_flat[i] > max_v) max_v = win_flat[i];
        end
    end

    median9 #(.PIX_W(PIX_W)) u_median9 (
        .pix (win_flat),
        .med (med_v)
    );

    // Columns 0/1 hold wrapped pixels from the previous row, rows 0/1 lack a full window.
    always_comb begin
        wr_en_d   = vld_q && (d_col_q >= CW'(2)) && (d_row_q >= RW'(2));
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_cnt_d  = start ? '0 : wr_cnt_q;
        if (wr_en_d) begin
            wr_addr_d = wr_cnt_q;
            wr_cnt_d  = wr_cnt_q + WA_W'(1);
            case (mode_q)
                MODE_MIN: wr_data_d = min_v;
                MODE_MAX: wr_data_d = max_v;
                MODE_MED: wr_data_d = med_v;
                default:  wr_data_d = win_d[1][1];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en_q) begin
            lb0_rd_q <= lb0_mem[rd_col_q];
            lb1_rd_q <= lb1_mem[rd_col_q];
        end
        if (vld_q) begin
            lb0_mem[d_col_q] <= rd_data;
            lb1_mem[d_col_q] <= lb0_rd_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            mode_q    <= MODE_PASS;
            drain_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_col_q  <= '0;
            rd_row_q  <= '0;
            vld_q     <= 1'b0;
            d_col_q   <= '0;
            d_row_q   <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_cnt_q  <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_col_q  <= rd_col_d;
            rd_row_q  <= rd_row_d;
            vld_q     <= vld_d;
            d_col_q   <= d_col_d;
            d_row_q   <= d_row_d;
            win_q     <= win_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
